// File: rtl/noobs_dmem_responder.sv
// Data-memory responder for the CPU data port: byte RAM below MMIO_BASE plus an MMIO window
// with GPIO, debug-transmit FIFO, FIFO status and a free-running cycle counter. Fixed 1-cycle read latency.
module noobs_dmem_responder #(
    parameter logic [11:0] MMIO_BASE  = 12'hFF0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        m_en,
    input  logic        m_rd,
    input  logic        m_wr,
    input  logic [11:0] m_addr,
    input  logic [7:0]  m_wr_data,
    output logic [7:0]  m_rd_data,
    output logic [7:0]  gpio_out,
    output logic [7:0]  dbg_data,
    output logic        dbg_vld,
    input  logic        dbg_rdy,
    output logic        err_access
);
    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          RAM_SIZE = int'(MMIO_BASE);
    localparam logic [11:0] A_GPIO   = MMIO_BASE;
    localparam logic [11:0] A_DBG    = MMIO_BASE + 12'd1;
    localparam logic [11:0] A_STAT   = MMIO_BASE + 12'd2;
    localparam logic [11:0] A_CYLO   = MMIO_BASE + 12'd3;
    localparam logic [11:0] A_CYHI   = MMIO_BASE + 12'd4;

    logic [7:0]    r_mem [0:RAM_SIZE-1];
    logic [7:0]    r_fifo [0:FIFO_DEPTH-1];
    logic [7:0]    r_ram_q;
    logic [7:0]    r_rd_data;
    logic          r_sel_ram;
    logic [7:0]    r_gpio;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic [15:0]   r_cyc;
    logic [7:0]    r_cyc_shadow;
    logic          r_err;

    logic          w_read;
    logic          w_write;
    logic          w_is_ram;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic [7:0]    w_status;
    logic [7:0]    w_mmio_rd;

    assign w_read     = m_en & m_rd & ~m_wr;
    assign w_write    = m_en & m_wr & ~m_rd;
    assign w_is_ram   = (m_addr < MMIO_BASE);
    assign w_empty    = (r_count == 3'd0);
    assign w_full     = (r_count == 3'(FIFO_DEPTH));
    assign w_pop      = ~w_empty & dbg_rdy;
    assign w_push_req = w_write & (m_addr == A_DBG);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_status   = {r_ovf, 2'b00, r_count, w_full, w_empty};

    always_comb begin
        w_mmio_rd = 8'h00;
        case (m_addr)
            A_GPIO:  w_mmio_rd = r_gpio;
            A_STAT:  w_mmio_rd = w_status;
            A_CYLO:  w_mmio_rd = r_cyc[7:0];
            A_CYHI:  w_mmio_rd = r_cyc_shadow;
            default: w_mmio_rd = 8'h00;
        endcase
    end

    // RAM kept free of reset so it maps onto block RAM; read data is held by the enable.
    always_ff @(posedge clk) begin
        if (w_write & w_is_ram) begin
            r_mem[m_addr] <= m_wr_data;
        end
        if (w_read & w_is_ram) begin
            r_ram_q <= r_mem[m_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= m_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_rd_data    <= 8'h00;
            r_sel_ram    <= 1'b0;
            r_gpio       <= 8'h00;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= 3'd0;
            r_ovf        <= 1'b0;
            r_cyc        <= 16'h0000;
            r_cyc_shadow <= 8'h00;
            r_err        <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 16'd1;
            r_err <= m_en & m_rd & m_wr;
            if (w_read) begin
                r_sel_ram <= w_is_ram;
                r_rd_data <= w_mmio_rd;
                if (m_addr == A_CYLO) begin
                    r_cyc_shadow <= r_cyc[15:8];
                end
            end
            if (w_write && (m_addr == A_GPIO)) begin
                r_gpio <= m_wr_data;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_write && (m_addr == A_STAT)) begin
                r_ovf <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_rd_data  = r_sel_ram ? r_ram_q : r_rd_data;
    assign gpio_out   = r_gpio;
    assign dbg_vld    = ~w_empty;
    assign dbg_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign err_access = r_err;

endmodule

// File: tb/tb_noobs_dmem_responder.sv
// Directed plus randomized bench for noobs_dmem_responder against a queue/array based behavioural model.
module tb_noobs_dmem_responder;
    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        m_en = 1'b0;
    logic        m_rd = 1'b0;
    logic        m_wr = 1'b0;
    logic [11:0] m_addr = 12'h000;
    logic [7:0]  m_wr_data = 8'h00;
    logic        dbg_rdy = 1'b0;
    logic [7:0]  m_rd_data;
    logic [7:0]  gpio_out;
    logic [7:0]  dbg_data;
    logic        dbg_vld;
    logic        err_access;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0] mdl_mem [int];
    logic [7:0] mdl_q [$];
    logic [7:0] mdl_gpio;
    logic [7:0] mdl_rd;
    bit         mdl_rd_known;
    logic [7:0] mdl_shadow;
    bit         mdl_ovf;
    bit         mdl_err;
    int         mdl_cyc;

    logic [7:0] lo_byte;
    logic [7:0] hi_byte;

    always #5 clk = ~clk;

    noobs_dmem_responder dut (
        .clk        (clk),
        .reset_     (reset_),
        .m_en       (m_en),
        .m_rd       (m_rd),
        .m_wr       (m_wr),
        .m_addr     (m_addr),
        .m_wr_data  (m_wr_data),
        .m_rd_data  (m_rd_data),
        .gpio_out   (gpio_out),
        .dbg_data   (dbg_data),
        .dbg_vld    (dbg_vld),
        .dbg_rdy    (dbg_rdy),
        .err_access (err_access)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_mem.delete();
        mdl_q.delete();
        mdl_gpio     = 8'h00;
        mdl_rd       = 8'h00;
        mdl_rd_known = 1'b1;
        mdl_shadow   = 8'h00;
        mdl_ovf      = 1'b0;
        mdl_err      = 1'b0;
        mdl_cyc      = 0;
    endtask

    function automatic logic [7:0] status_byte();
        int n = mdl_q.size();
        logic [2:0] cnt = n[2:0];
        return {mdl_ovf, 2'b00, cnt, (n == 4), (n == 0)};
    endfunction

    task automatic model_step(input bit en, input bit rd, input bit wr, input logic [11:0] addr,
                              input logic [7:0] data, input bit rdy);
        bit is_read  = en && rd && !wr;
        bit is_write = en && wr && !rd;
        bit was_full = (mdl_q.size() == 4);
        bit pop      = (mdl_q.size() > 0) && rdy;
        logic [15:0] cval = mdl_cyc[15:0];
        if (is_read) begin
            mdl_rd_known = 1'b1;
            if (addr < 12'hFF0) begin
                if (mdl_mem.exists(int'(addr))) mdl_rd = mdl_mem[int'(addr)];
                else mdl_rd_known = 1'b0;
            end else begin
                case (addr)
                    12'hFF0: mdl_rd = mdl_gpio;
                    12'hFF2: mdl_rd = status_byte();
                    12'hFF3: begin mdl_rd = cval[7:0]; mdl_shadow = cval[15:8]; end
                    12'hFF4: mdl_rd = mdl_shadow;
                    default: mdl_rd = 8'h00;
                endcase
            end
        end
        if (pop) void'(mdl_q.pop_front());
        if (is_write) begin
            if (addr < 12'hFF0) mdl_mem[int'(addr)] = data;
            else if (addr == 12'hFF0) mdl_gpio = data;
            else if (addr == 12'hFF1) begin
                if (!was_full || pop) mdl_q.push_back(data);
                else mdl_ovf = 1'b1;
            end else if (addr == 12'hFF2) mdl_ovf = 1'b0;
        end
        mdl_err = en && rd && wr;
        mdl_cyc++;
    endtask

    task automatic check_outputs(input string tag);
        if (mdl_rd_known) chk({tag, "_rd"}, 16'(m_rd_data), 16'(mdl_rd));
        chk({tag, "_gpio"}, 16'(gpio_out), 16'(mdl_gpio));
        chk({tag, "_vld"}, 16'(dbg_vld), 16'(mdl_q.size() > 0));
        chk({tag, "_dbg"}, 16'(dbg_data), (mdl_q.size() > 0) ? 16'(mdl_q[0]) : 16'h0000);
        chk({tag, "_err"}, 16'(err_access), 16'(mdl_err));
    endtask

    // One bus cycle: drive at the falling edge, the DUT samples at the rising edge, check at the next falling edge.
    task automatic do_cycle(input bit en, input bit rd, input bit wr, input logic [11:0] addr,
                            input logic [7:0] data, input bit rdy, input string tag);
        m_en = en; m_rd = rd; m_wr = wr; m_addr = addr; m_wr_data = data; dbg_rdy = rdy;
        model_step(en, rd, wr, addr, data, rdy);
        @(posedge clk);
        @(negedge clk);
        $display("txn %s en=%0b rd=%0b wr=%0b addr=%h wdata=%h rdata=%h gpio=%h vld=%0b dbg=%h err=%0b",
                 tag, en, rd, wr, addr, data, m_rd_data, gpio_out, dbg_vld, dbg_data, err_access);
        check_outputs(tag);
    endtask

    task automatic idle_run(input int n);
        m_en = 1'b0; m_rd = 1'b0; m_wr = 1'b0; dbg_rdy = 1'b0;
        repeat (n) @(negedge clk);
        mdl_cyc += n;
        mdl_err = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_rd", 16'(m_rd_data), 16'h0000);
        chk("rst_gpio", 16'(gpio_out), 16'h0000);
        chk("rst_vld", 16'(dbg_vld), 16'h0000);
        chk("rst_dbg", 16'(dbg_data), 16'h0000);
        chk("rst_err", 16'(err_access), 16'h0000);
        @(negedge clk);
        reset_ = 1'b1;

        // RAM write then read, data holds while idle
        do_cycle(1, 0, 1, 12'h010, 8'h5A, 0, "ram_wr");
        do_cycle(1, 1, 0, 12'h010, 8'h00, 0, "ram_rd");
        chk("ram_rd_val", 16'(m_rd_data), 16'h005A);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 12'h000, 8'h00, 0, "ram_hold");

        // GPIO, then asynchronous reset with a byte queued in the FIFO
        do_cycle(1, 0, 1, 12'hFF0, 8'hC3, 0, "gpio_wr");
        chk("gpio_val", 16'(gpio_out), 16'h00C3);
        do_cycle(1, 1, 0, 12'hFF0, 8'h00, 0, "gpio_rd");
        do_cycle(1, 0, 1, 12'hFF1, 8'hAB, 0, "pre_rst_push");
        do_cycle(0, 0, 0, 12'h000, 8'h00, 0, "pre_rst_idle");
        #2;
        reset_ = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        reset_ = 1'b1;

        // Overflow then drain
        for (int i = 1; i <= 5; i++) do_cycle(1, 0, 1, 12'hFF1, 8'(i * 8'h11), 0, "push");
        do_cycle(1, 1, 0, 12'hFF2, 8'h00, 0, "stat_ovf");
        chk("stat_ovf_val", 16'(m_rd_data), 16'h0092);
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 12'h000, 8'h00, 1, "drain");
        do_cycle(1, 0, 1, 12'hFF2, 8'h00, 0, "stat_clr");
        do_cycle(1, 1, 0, 12'hFF2, 8'h00, 0, "stat_empty");
        chk("stat_empty_val", 16'(m_rd_data), 16'h0001);

        // Push into a full FIFO while the head pops
        for (int i = 1; i <= 4; i++) do_cycle(1, 0, 1, 12'hFF1, 8'(8'h60 + i), 0, "fill");
        do_cycle(1, 0, 1, 12'hFF1, 8'h66, 1, "push_pop_full");
        do_cycle(1, 1, 0, 12'hFF2, 8'h00, 0, "stat_full");
        chk("stat_full_val", 16'(m_rd_data), 16'h0012);
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 12'h000, 8'h00, 1, "drain2");

        // Coherent counter read across a low-byte rollover
        idle_run(16'h01FF - mdl_cyc);
        do_cycle(1, 1, 0, 12'hFF3, 8'h00, 0, "cyc_lo");
        lo_byte = m_rd_data;
        do_cycle(1, 1, 0, 12'hFF4, 8'h00, 0, "cyc_hi");
        hi_byte = m_rd_data;
        chk("cyc_pair", {hi_byte, lo_byte}, 16'h01FF);
        do_cycle(1, 0, 1, 12'hFF3, 8'h77, 0, "cyc_wr_ign");

        // Counter wrap FFFF -> 0000
        idle_run(32'h0000FFFF - mdl_cyc);
        do_cycle(1, 1, 0, 12'hFF3, 8'h00, 0, "cyc_top");
        chk("cyc_top_lo", 16'(m_rd_data), 16'h00FF);
        do_cycle(1, 1, 0, 12'hFF3, 8'h00, 0, "cyc_wrap_lo");
        chk("cyc_wrap_lo_val", 16'(m_rd_data), 16'h0000);
        do_cycle(1, 1, 0, 12'hFF4, 8'h00, 0, "cyc_wrap_hi");
        chk("cyc_wrap_hi_val", 16'(m_rd_data), 16'h0000);

        // Illegal access and disabled access
        do_cycle(1, 0, 1, 12'h010, 8'h77, 0, "ill_prep_wr");
        do_cycle(1, 1, 0, 12'h010, 8'h00, 0, "ill_prep_rd");
        do_cycle(1, 1, 1, 12'h010, 8'h99, 0, "illegal");
        chk("illegal_err", 16'(err_access), 16'h0001);
        do_cycle(0, 0, 0, 12'h000, 8'h00, 0, "ill_after");
        do_cycle(1, 1, 0, 12'h010, 8'h00, 0, "ill_ram_rd");
        chk("ill_ram_val", 16'(m_rd_data), 16'h0077);
        do_cycle(0, 1, 1, 12'h010, 8'h55, 0, "en_off");
        do_cycle(1, 1, 0, 12'h010, 8'h00, 0, "en_off_rd");

        // Randomized traffic over a small RAM slice and the whole MMIO window
        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            int sel;
            bit en, rd, wr;
            a = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 15))
                                            : 12'(12'hFF0 + 12'($urandom_range(0, 15)));
            sel = $urandom_range(0, 9);
            en = ($urandom_range(0, 7) != 0);
            rd = (sel <= 3) || (sel == 8);
            wr = (sel >= 4 && sel <= 8);
            do_cycle(en, rd, wr, a, 8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noobs_dmem_responder.md
Name: noobs_dmem_responder

Overview:
- Data-memory responder on the far end of the CPU data-memory port (m_addr / m_wr_data / m_rd_data / m_rd / m_wr / m_en).
- Serves byte-wide RAM over the low address space.
- Serves a memory-mapped I/O window at the top of the 12-bit space: GPIO output register, debug-transmit FIFO with ready/valid drain port, status register, free-running cycle counter.
- Fixed latency; no wait states, because the CPU has no stall input.

Parameters:
- MMIO_BASE, 12'hFF0, first MMIO address; RAM occupies 0 to MMIO_BASE-1.
- FIFO_DEPTH, 4, debug FIFO entries; must be a power of two, max 4 (count field is 3 bits).

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- m_en  in  1  access enable; m_rd/m_wr ignored when 0
- m_rd  in  1  read request
- m_wr  in  1  write request
- m_addr  in  12  byte address
- m_wr_data  in  8  write data
- m_rd_data  out  8  registered read data
- gpio_out  out  8  GPIO output register
- dbg_data  out  8  FIFO head byte
- dbg_vld  out  1  FIFO non-empty
- dbg_rdy  in  1  consumer accepts head
- err_access  out  1  one-cycle pulse on illegal access

Behaviour:
- Reset (async assert, sync release):
  - Outputs: m_rd_data=0, gpio_out=0, dbg_vld=0, dbg_data=0, err_access=0.
  - Internal: FIFO empty, overflow flag=0, cycle counter=0, CYC_HI shadow=0.
  - RAM contents are not reset (undefined until written).
- Access decode, sampled at posedge:
  - read = m_en & m_rd & ~m_wr
  - write = m_en & m_wr & ~m_rd
  - m_en & m_rd & m_wr is illegal: no state change, m_rd_data holds, err_access=1 the next cycle only.
  - m_en=0: no access, no error.
- Read latency 1: m_rd_data is updated at the edge that samples the read. It is valid the following cycle and holds until the next read.
- Writes commit at the sampling edge. A read of the same address in the next cycle returns the new value.
- MMIO map:
  - FF0 GPIO: R/W.
  - FF1 DBG_TX: write pushes m_wr_data into FIFO; read returns 0.
  - FF2 STATUS: read returns bit0 empty, bit1 full, bits4:2 count, bits6:5 zero, bit7 overflow (sticky). Any write clears overflow.
  - FF3 CYC_LO: read returns counter[7:0] and, in the same edge, captures counter[15:8] into the shadow.
  - FF4 CYC_HI: read returns the shadow, so a LO-then-HI pair is coherent.
  - FF5-FFF: reserved; read 0, writes ignored, no error.
- Cycle counter:
  - 16-bit, +1 every cycle out of reset.
  - Wraps FFFF->0000.
  - Writes to FF3/FF4 are ignored.
- Debug FIFO:
  - dbg_vld = ~empty; dbg_data = head entry.
  - Pop when dbg_vld & dbg_rdy at posedge.
  - Push when FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Push into a full FIFO with no pop: byte dropped, overflow set.
  - Push while empty: dbg_vld rises the next cycle (no bypass).
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-transfer aborts everything: in-flight read data is lost, FIFO contents are discarded, and all outputs go to reset values immediately.

Test Plan:
1. Write 0x5A to 0x010; next cycle read 0x010 -> m_rd_data=0x5A one cycle after the read edge; it holds 0x5A through 3 idle cycles.
2. Write 0xC3 to FF0 -> gpio_out=0xC3 after the edge. Read FF0 -> 0xC3. Assert reset_=0 mid-cycle -> gpio_out=0 without waiting for clk.
3. With dbg_rdy=0, push 0x11,0x22,0x33,0x44,0x55 to FF1 -> STATUS reads 0x92 (overflow=1, count=4, full=1). Raise dbg_rdy -> dbg_data sequence 11,22,33,44, then dbg_vld=0. Write FF2 -> STATUS reads 0x01.
4. FIFO full, dbg_rdy=1, push 0x66 in the same cycle -> no overflow; count stays 4; 0x66 is delivered last.
5. After 0x1FF cycles of reset release, read FF3 then FF4 -> the LO and HI bytes form the counter value at the FF3 edge, even if LO wraps between the reads. Also run the counter across FFFF -> it reads 0000.
6. Drive m_en=1, m_rd=1, m_wr=1 at 0x010 -> err_access=1 for exactly one cycle, RAM[0x010] unchanged, m_rd_data unchanged. Drive m_en=0 with m_rd=m_wr=1 -> no error and no access.
